// File: rtl/param_counter.sv
// Parameterised up/down counter with a prescaler, wrap or saturate at the
// boundaries, a terminal-count pulse and a sticky overflow flag.
// The count range is 0..limit. A load strobe overrides all counting.
module param_counter #(
    parameter int WIDTH = 64,
    parameter int PW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             sat,
    input  logic [PW-1:0]    presc,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf_flag
);

    logic [PW-1:0]    pcnt;
    logic             tick;
    logic             at_up;
    logic             at_down;
    logic             boundary_tick;
    logic [WIDTH-1:0] next_count;

    // A value above limit (reachable through load) counts as the up boundary.
    assign at_up   = (out >= limit);
    assign at_down = (out == '0);

    // Load suppresses the tick entirely, so it also suppresses tc and ovf.
    assign tick          = en && !load && (pcnt >= presc);
    assign boundary_tick = tick && (dir ? at_up : at_down);

    // Next count value for a tick, covering stepping, wrapping and saturation
    always_comb begin
        next_count = out;
        if (dir) begin
            if (at_up)
                next_count = sat ? limit : '0;
            else
                next_count = out + 1'b1;
        end else begin
            if (at_down)
                next_count = sat ? '0 : limit;
            else
                next_count = out - 1'b1;
        end
    end

    // Prescaler: counts enabled cycles and restarts on every tick or load
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pcnt <= '0;
        else if (load)
            pcnt <= '0;
        else if (tick)
            pcnt <= '0;
        else if (en)
            pcnt <= pcnt + 1'b1;
    end

    // Count register: load wins, otherwise advance only on a prescaler tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            out <= '0;
        else if (load)
            out <= load_val;
        else if (tick)
            out <= next_count;
    end

    // Terminal-count pulse for every tick taken at a boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tc <= 1'b0;
        else
            tc <= boundary_tick;
    end

    // Sticky overflow on a wrap; a new wrap beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_flag <= 1'b0;
        else if (boundary_tick && !sat)
            ovf_flag <= 1'b1;
        else if (ovf_clr)
            ovf_flag <= 1'b0;
    end

endmodule

// File: tb/tb_param_counter.sv
// Directed self-checking bench for param_counter: an 8-bit instance for the
// functional cases and a 64-bit instance for the full-range wrap.
module tb_param_counter;

    logic clk;
    logic reset;

    logic       en8, dir8, load8, sat8, ovfClr8;
    logic [7:0] loadVal8, limit8, presc8;
    logic [7:0] out8;
    logic       tc8, ovf8;

    logic        en64, dir64, load64, sat64, ovfClr64;
    logic [63:0] loadVal64, limit64;
    logic [7:0]  presc64;
    logic [63:0] out64;
    logic        tc64, ovf64;

    int checks;
    int failures;

    param_counter #(.WIDTH(8), .PW(8)) dut8 (
        .clk(clk), .reset(reset), .en(en8), .dir(dir8), .load(load8),
        .load_val(loadVal8), .limit(limit8), .sat(sat8), .presc(presc8),
        .ovf_clr(ovfClr8), .out(out8), .tc(tc8), .ovf_flag(ovf8)
    );

    param_counter #(.WIDTH(64), .PW(8)) dut64 (
        .clk(clk), .reset(reset), .en(en64), .dir(dir64), .load(load64),
        .load_val(loadVal64), .limit(limit64), .sat(sat64), .presc(presc64),
        .ovf_clr(ovfClr64), .out(out64), .tc(tc64), .ovf_flag(ovf64)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic dir, input logic load,
                                 input logic [7:0] loadVal, input logic [7:0] limit,
                                 input logic sat, input logic [7:0] presc,
                                 input logic ovfClr);
        en8 = en; dir8 = dir; load8 = load; loadVal8 = loadVal;
        limit8 = limit; sat8 = sat; presc8 = presc; ovfClr8 = ovfClr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] expOut [8];
    logic [7:0] expPre [11];
    logic [7:0] expSat [4];
    logic       expSatTc [4];

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'd5, 1'b0, 8'd0, 1'b0);
        en64 = 1'b0; dir64 = 1'b1; load64 = 1'b0; sat64 = 1'b0; ovfClr64 = 1'b0;
        loadVal64 = '0; limit64 = '1; presc64 = 8'd0;

        #3;
        checkOutput("reset_out", 64'(out8), 64'h0);
        checkOutput("reset_tc", 64'(tc8), 64'h0);
        checkOutput("reset_ovf", 64'(ovf8), 64'h0);

        // Basic wrap: limit 5, one step per clock
        step();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'd5, 1'b0, 8'd0, 1'b0);
        expOut = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput($sformatf("wrap_out%0d", i), 64'(out8), 64'(expOut[i]));
            checkOutput($sformatf("wrap_tc%0d", i), 64'(tc8), (i == 5) ? 64'h1 : 64'h0);
            if (i == 4)
                checkOutput("wrap_ovf_before", 64'(ovf8), 64'h0);
        end
        checkOutput("wrap_ovf_after", 64'(ovf8), 64'h1);

        // Clear the flag while disabled; count holds
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'd5, 1'b0, 8'd0, 1'b1);
        step();
        checkOutput("clr_ovf", 64'(ovf8), 64'h0);
        checkOutput("clr_hold_out", 64'(out8), 64'd2);
        checkOutput("clr_tc", 64'(tc8), 64'h0);

        // Prescaler of 3 with a two-cycle enable gap
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'd5, 1'b0, 8'd2, 1'b0);
        step();
        checkOutput("presc_load", 64'(out8), 64'd0);
        expPre = '{8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};
        for (int i = 0; i < 11; i++) begin
            applyStimulus((i == 6 || i == 7) ? 1'b0 : 1'b1, 1'b1, 1'b0, 8'h00, 8'd5,
                          1'b0, 8'd2, 1'b0);
            step();
            if (i != 3 && i != 4)
                checkOutput($sformatf("presc_out%0d", i), 64'(out8), 64'(expPre[i]));
        end

        // Saturating down count from 2
        applyStimulus(1'b1, 1'b0, 1'b1, 8'd2, 8'd5, 1'b1, 8'd0, 1'b0);
        step();
        checkOutput("sat_load", 64'(out8), 64'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd5, 1'b1, 8'd0, 1'b0);
        expSat = '{8'd1, 8'd0, 8'd0, 8'd0};
        expSatTc = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput($sformatf("sat_out%0d", i), 64'(out8), 64'(expSat[i]));
            checkOutput($sformatf("sat_tc%0d", i), 64'(tc8), 64'(expSatTc[i]));
        end
        checkOutput("sat_ovf", 64'(ovf8), 64'h0);

        // Load colliding with a boundary tick; loaded value above limit
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hAA, 8'd5, 1'b1, 8'd0, 1'b0);
        step();
        checkOutput("ldcol_out", 64'(out8), 64'hAA);
        checkOutput("ldcol_tc", 64'(tc8), 64'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'd5, 1'b0, 8'd1, 1'b0);
        step();
        checkOutput("above_wait", 64'(out8), 64'hAA);
        step();
        checkOutput("above_out", 64'(out8), 64'h0);
        checkOutput("above_tc", 64'(tc8), 64'h1);
        checkOutput("above_ovf", 64'(ovf8), 64'h1);

        // Clear, then a wrap racing a clear: the set wins
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'd5, 1'b0, 8'd0, 1'b1);
        step();
        checkOutput("race_pre_ovf", 64'(ovf8), 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'd5, 1'b0, 8'd0, 1'b1);
        step();
        checkOutput("race_out", 64'(out8), 64'd5);
        checkOutput("race_ovf", 64'(ovf8), 64'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'd5, 1'b0, 8'd0, 1'b0);

        // Full 64-bit range: FFFE -> FFFF -> 0
        load64 = 1'b1; loadVal64 = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        load64 = 1'b0; en64 = 1'b1;
        step();
        checkOutput("w64_step", out64, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("w64_step_tc", 64'(tc64), 64'h0);
        step();
        checkOutput("w64_wrap", out64, 64'h0);
        checkOutput("w64_tc", 64'(tc64), 64'h1);
        checkOutput("w64_ovf", 64'(ovf64), 64'h1);
        en64 = 1'b0;

        // Asynchronous reset between clock edges
        #2;
        reset = 1'b1;
        #1;
        checkOutput("areset_out8", 64'(out8), 64'h0);
        checkOutput("areset_ovf8", 64'(ovf8), 64'h0);
        checkOutput("areset_out64", out64, 64'h0);
        checkOutput("areset_tc64", 64'(tc64), 64'h0);
        checkOutput("areset_ovf64", 64'(ovf64), 64'h0);

        // Restart after reset: first tick after presc+1 enabled cycles
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 8'd5, 1'b0, 8'd2, 1'b0);
        #2;
        reset = 1'b0;
        step();
        checkOutput("restart0", 64'(out8), 64'd0);
        step();
        checkOutput("restart1", 64'(out8), 64'd0);
        step();
        checkOutput("restart2", 64'(out8), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 64: counter width in bits, legal range 2..64.
REQ-002 Parameter PW, default 8: prescaler width in bits, legal range 1..16.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count enable; low freezes the counter and the prescaler.
REQ-006 dir  input  1  count direction; 1 = up, 0 = down.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  WIDTH  value written to out on load.
REQ-009 limit  input  WIDTH  terminal value; the count range is 0..limit.
REQ-010 sat  input  1  boundary mode; 1 = saturate, 0 = wrap.
REQ-011 presc  input  PW  prescale value; one count step every presc+1 enabled cycles.
REQ-012 ovf_clr  input  1  clears ovf_flag.
REQ-013 out  output  WIDTH  registered count value.
REQ-014 tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-015 ovf_flag  output  1  sticky wrap indicator.

Function
REQ-016 Internal prescaler register pcnt (PW bits) SHALL increment on each clk with en=1 and load=0; the tick condition SHALL be (pcnt >= presc) and en=1; on a tick pcnt SHALL clear to 0.
REQ-017 With presc=0, a tick SHALL occur on every enabled cycle, giving one step per clk.
REQ-018 The up boundary SHALL be out >= limit; the down boundary SHALL be out == 0.
REQ-019 On a tick with dir=1 and out not at the up boundary, out SHALL become out+1.
REQ-020 On a tick with dir=0 and out not at the down boundary, out SHALL become out-1.
REQ-021 On a tick at the up boundary: with sat=0, out SHALL become 0; with sat=1, out SHALL become limit.
REQ-022 On a tick at the down boundary: with sat=0, out SHALL become limit; with sat=1, out SHALL hold 0.
REQ-023 tc SHALL be 1 in the cycle after any tick taken at a boundary (wrap or saturate hold), and 0 otherwise; a saturated counter SHALL pulse tc on every tick while held.
REQ-024 ovf_flag SHALL set in the cycle after a boundary tick with sat=0, and SHALL hold until ovf_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-025 load=1 SHALL take priority over counting: out SHALL become load_val, pcnt SHALL become 0, no tick SHALL occur and tc SHALL be 0, regardless of en.
REQ-026 load_val greater than limit SHALL be accepted unchanged; the next up tick SHALL then treat out as at the boundary per REQ-021.
REQ-027 When en=0 and load=0, out, pcnt and ovf_flag (except clearing by ovf_clr) SHALL hold, and tc SHALL be 0.
REQ-028 Changes to dir, limit, sat or presc SHALL take effect on the next clk edge with no restart of pcnt.
REQ-029 Arithmetic SHALL be unsigned modulo 2^WIDTH; limit = 2^WIDTH-1 SHALL give full-range counting.

Reset
REQ-030 While reset=1: out=0, pcnt=0, tc=0 and ovf_flag=0, asynchronously and independent of clk.
REQ-031 Reset deasserted mid-count SHALL restart from out=0 with pcnt=0; the first tick SHALL occur presc+1 enabled cycles later.

Verification
REQ-032 WIDTH=8, limit=5, presc=0, dir=1, sat=0, en=1 for 8 cycles -> out 1,2,3,4,5,0,1,2; tc high for one cycle after the 5->0 step; ovf_flag=1.
REQ-033 presc=2, dir=1, en=1 from out=0 -> out increments every 3rd cycle; toggling en low for 2 cycles stretches the interval by exactly 2.
REQ-034 sat=1, dir=0, out=2, presc=0 -> out 1,0,0,0; tc=1 on each hold cycle after reaching 0; ovf_flag stays 0.
REQ-035 load=1 with load_val=0xAA, en=1, simultaneous with a boundary tick -> out=0xAA, tc=0, pcnt=0; ovf_clr and a wrap in the same cycle -> ovf_flag=1.
REQ-036 WIDTH=64, limit=all-ones, load_val=all-ones, dir=1 tick -> out=0, tc=1; async reset pulse between clk edges -> all outputs 0 immediately.
